// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns single read/write commands into APB transfers and
// returns one response per command. A wait counter aborts transfers whose
// slave never raises p_ready.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | APB setup phase (p_sel=1, p_en=0), one cycle
// ACCESS | APB access phase (p_sel=1, p_en=1), waiting for p_ready or timeout
// RESP   | response presented, waiting for rsp_ready
module apb_cmd_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        p_sel,
  output logic        p_en,
  output logic        p_wr,
  output logic [31:0] p_addr,
  output logic [31:0] pw_data,
  input  logic        p_ready,
  input  logic [31:0] pr_data,
  input  logic        pslverr
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Abort is taken in the ACCESS cycle whose increment would bring the count
  // to TIMEOUT, so exactly TIMEOUT low-ready ACCESS cycles are spent.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic          p_sel_q, p_sel_d;
  logic          p_en_q, p_en_d;
  logic          p_wr_q, p_wr_d;
  logic [31:0]   p_addr_q, p_addr_d;
  logic [31:0]   pw_data_q, pw_data_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge pclk) begin
    if (!prst) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      p_sel_q       <= 1'b0;
      p_en_q        <= 1'b0;
      p_wr_q        <= 1'b0;
      p_addr_q      <= '0;
      pw_data_q     <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      p_sel_q       <= p_sel_d;
      p_en_q        <= p_en_d;
      p_wr_q        <= p_wr_d;
      p_addr_q      <= p_addr_d;
      pw_data_q     <= pw_data_d;
      cnt_q         <= cnt_d;
    end
  end

  // Next-state and next-output decode; everything holds unless changed.
  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    p_sel_d       = p_sel_q;
    p_en_d        = p_en_q;
    p_wr_d        = p_wr_q;
    p_addr_d      = p_addr_q;
    pw_data_d     = pw_data_q;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          p_wr_d      = cmd_wr;
          p_addr_d    = cmd_addr;
          pw_data_d   = cmd_wdata;
          p_sel_d     = 1'b1;
          p_en_d      = 1'b0;
          cmd_ready_d = 1'b0;
          cnt_d       = '0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        p_en_d  = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (p_ready) begin
          rsp_rdata_d   = p_wr_q ? 32'h0 : pr_data;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          p_sel_d       = 1'b0;
          p_en_d        = 1'b0;
          state_d       = RESP;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          rsp_rdata_d   = 32'h0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          p_sel_d       = 1'b0;
          p_en_d        = 1'b0;
          state_d       = RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign p_sel       = p_sel_q;
  assign p_en        = p_en_q;
  assign p_wr        = p_wr_q;
  assign p_addr      = p_addr_q;
  assign pw_data     = pw_data_q;

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameter: TIMEOUT, 255, ACCESS-phase cycles with p_ready low before abort; 0 disables timeout.
REQ-002 Port: pclk  input  1  sole clock; all logic on rising edge.
REQ-003 Port: prst  input  1  reset, synchronous, active-low.
REQ-004 Port: cmd_valid  input  1  command request.
REQ-005 Port: cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-006 Port: cmd_wr  input  1  1 = write, 0 = read.
REQ-007 Port: cmd_addr  input  32  target register address, passed unmodified to p_addr.
REQ-008 Port: cmd_wdata  input  32  write data.
REQ-009 Port: rsp_valid  output  1  response available.
REQ-010 Port: rsp_ready  input  1  response consumed when rsp_valid & rsp_ready.
REQ-011 Port: rsp_rdata  output  32  read data; 0 for writes and timeouts.
REQ-012 Port: rsp_err  output  1  pslverr seen, or timeout.
REQ-013 Port: rsp_timeout  output  1  transfer aborted by timeout.
REQ-014 Port: p_sel  output  1  APB select to UART slave.
REQ-015 Port: p_en  output  1  APB enable.
REQ-016 Port: p_wr  output  1  APB write.
REQ-017 Port: p_addr  output  32  APB address.
REQ-018 Port: pw_data  output  32  APB write data.
REQ-019 Port: p_ready  input  1  slave ready.
REQ-020 Port: pr_data  input  32  slave read data.
REQ-021 Port: pslverr  input  1  slave error, valid with p_ready.

Function
REQ-022 FSM states IDLE, SETUP, ACCESS, RESP; all outputs registered.
REQ-023 cmd_ready SHALL be 1 only in IDLE; cmd_valid in other states is not accepted and has no effect.
REQ-024 On accept in IDLE: latch cmd_wr/addr/wdata into p_wr/p_addr/pw_data; next state SETUP.
REQ-025 SETUP: p_sel=1, p_en=0, exactly one cycle; next state ACCESS.
REQ-026 ACCESS: p_sel=1, p_en=1; p_addr, p_wr, pw_data stable from SETUP through last ACCESS cycle.
REQ-027 ACCESS with p_ready=1: capture rsp_rdata = pr_data if read else 0; rsp_err = pslverr; rsp_timeout=0; p_sel=p_en=0; next state RESP.
REQ-028 Wait counter clears on SETUP entry and increments each ACCESS cycle with p_ready=0; width ceil(log2(TIMEOUT+1)), never wraps.
REQ-029 With TIMEOUT>0, when the counter reaches TIMEOUT and p_ready=0: rsp_err=1, rsp_timeout=1, rsp_rdata=0, p_sel=p_en=0, next state RESP; p_ready=1 in that same cycle wins (REQ-027 applies).
REQ-030 RESP: rsp_valid=1; rsp_rdata/err/timeout held until rsp_valid & rsp_ready; then IDLE, rsp_valid=0 next cycle.
REQ-031 Latency, zero-wait slave: accept at cycle N -> SETUP at N+1 -> ACCESS at N+2 -> rsp_valid at N+3; next accept no earlier than the cycle after the response handshake.
REQ-032 p_addr, p_wr, pw_data hold last values outside transfers.

Reset
REQ-033 prst=0 sampled on a rising edge SHALL force IDLE and p_sel=p_en=p_wr=0, p_addr=pw_data=0, rsp_valid=rsp_err=rsp_timeout=0, rsp_rdata=0, counter=0; cmd_ready=1 from the first cycle after prst returns high.
REQ-034 Reset mid-transfer (SETUP/ACCESS/RESP) SHALL abort without a response; the pending response is discarded.

Verification
REQ-035 Write addr 0x0, data 0x0000_0778, p_ready=1 -> p_sel at N+1, p_en at N+2, rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
REQ-036 Read addr 0x3, p_ready low 3 ACCESS cycles then high with pr_data=0x0000_00A5 -> rsp_rdata=0x0000_00A5 at N+6, p_addr=0x3 stable throughout.
REQ-037 Write addr 0x2, data 0x3a3a_3a3a, slave returns pslverr=1 with p_ready -> rsp_err=1, rsp_timeout=0.
REQ-038 TIMEOUT=16, p_ready stuck 0 -> abort after 16 ACCESS cycles, p_sel=p_en=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-039 rsp_ready held low 5 cycles with cmd_valid=1 -> rsp_valid and data held, cmd_ready=0, no APB activity; accept resumes after the handshake.
REQ-040 prst=0 during ACCESS -> next edge p_sel=p_en=0, rsp_valid=0, state IDLE; no response ever issued for the aborted command.
